// File: rtl/alu_flags_mul_if.sv
// ---------------------------------------------------------------------------
// alu_flags_mul_if
// Groups the operand, control, result-bus and flag signals of the ALU.
//   a, b    : operands (A and B registers)
//   op      : operation select (ADD, SUB, ADC, SBC, AND, OR, XOR, MUL)
//   start   : begin a multiply (only with op = MUL and not busy)
//   eo_     : active-low output enable of the result onto bus
//   fi_     : active-low flags-in strobe
//   bus     : result, high-Z when eo_ = 1
//   cf/zf/nf/vf : registered carry, zero, negative, overflow flags
//   busy    : multiply in progress
// The master modport is the controlling side; the slave modport is the ALU.
// ---------------------------------------------------------------------------
interface alu_flags_mul_if #(
    parameter int N = 8
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         start;
    logic         eo_;
    logic         fi_;
    logic [N-1:0] bus;
    logic         cf;
    logic         zf;
    logic         nf;
    logic         vf;
    logic         busy;

    modport master (
        output a, b, op, start, eo_, fi_,
        input  bus, cf, zf, nf, vf, busy
    );

    modport slave (
        input  a, b, op, start, eo_, fi_,
        output bus, cf, zf, nf, vf, busy
    );
endinterface

// File: rtl/alu_flags_mul.sv
// ---------------------------------------------------------------------------
// alu_flags_mul
// N-bit ALU with a latched C/Z/N/V flag register and a multi-cycle
// shift-add multiplier.
//   clk    : system clock, rising edge
//   rst_   : asynchronous active-low reset
//   bus_if : slave side of alu_flags_mul_if (operands, op, start, eo_,
//            fi_, tri-state result bus, flags, busy)
// Ops 000-110 are combinational onto the bus; op 111 shows the multiply
// result register (in-progress contents while busy).
// ---------------------------------------------------------------------------
module alu_flags_mul #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_,
    alu_flags_mul_if.slave      bus_if
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [2*N-1:0] prod_r;
    logic [2*N-1:0] prod_nxt_s;
    logic [N-1:0]   mcand_r;
    logic [N-1:0]   mcand_nxt_s;
    logic [N-1:0]   mplier_r;
    logic [N-1:0]   mplier_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nxt_s;
    logic [N:0]     part_s;

    logic           cf_r;
    logic           zf_r;
    logic           nf_r;
    logic           vf_r;
    logic           cf_nxt_s;
    logic           vf_nxt_s;

    logic [N-1:0]   b_op_s;
    logic           cin_s;
    logic [N:0]     sum_s;
    logic [N-1:0]   res_s;
    logic           busy_s;

    assign busy_s = (state_r == RUN);

    // Adder operand/carry-in selection: subtracts use the inverted B operand.
    always_comb begin
        b_op_s = bus_if.b;
        cin_s  = 1'b0;
        case (bus_if.op)
            3'b001: begin
                b_op_s = ~bus_if.b;
                cin_s  = 1'b1;
            end
            3'b010: begin
                b_op_s = bus_if.b;
                cin_s  = cf_r;
            end
            3'b011: begin
                b_op_s = ~bus_if.b;
                cin_s  = cf_r;
            end
            default: begin
                b_op_s = bus_if.b;
                cin_s  = 1'b0;
            end
        endcase
        sum_s = {1'b0, bus_if.a} + {1'b0, b_op_s} + {{N{1'b0}}, cin_s};
    end

    // Result and next-flag values for the currently selected operation.
    always_comb begin
        res_s    = sum_s[N-1:0];
        cf_nxt_s = sum_s[N];
        vf_nxt_s = (bus_if.a[N-1] == b_op_s[N-1]) && (sum_s[N-1] != bus_if.a[N-1]);
        case (bus_if.op)
            3'b100: begin
                res_s    = bus_if.a & bus_if.b;
                cf_nxt_s = 1'b0;
                vf_nxt_s = 1'b0;
            end
            3'b101: begin
                res_s    = bus_if.a | bus_if.b;
                cf_nxt_s = 1'b0;
                vf_nxt_s = 1'b0;
            end
            3'b110: begin
                res_s    = bus_if.a ^ bus_if.b;
                cf_nxt_s = 1'b0;
                vf_nxt_s = 1'b0;
            end
            3'b111: begin
                // A non-zero upper half means the product does not fit in N bits.
                res_s    = prod_r[N-1:0];
                cf_nxt_s = |prod_r[2*N-1:N];
                vf_nxt_s = |prod_r[2*N-1:N];
            end
            default: begin
                res_s    = sum_s[N-1:0];
                cf_nxt_s = sum_s[N];
                vf_nxt_s = (bus_if.a[N-1] == b_op_s[N-1]) && (sum_s[N-1] != bus_if.a[N-1]);
            end
        endcase
    end

    // Multiply FSM next-state and shift-add datapath.
    always_comb begin
        state_nxt_s  = state_r;
        prod_nxt_s   = prod_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        cnt_nxt_s    = cnt_r;
        part_s       = {1'b0, prod_r[2*N-1:N]};
        case (state_r)
            IDLE: begin
                if (bus_if.start && (bus_if.op == 3'b111)) begin
                    mcand_nxt_s  = bus_if.a;
                    mplier_nxt_s = bus_if.b;
                    prod_nxt_s   = {(2*N){1'b0}};
                    cnt_nxt_s    = CW'(N);
                    state_nxt_s  = RUN;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            RUN: begin
                // The adder carry becomes the bit shifted into the product MSB.
                if (mplier_r[0]) begin
                    part_s = {1'b0, prod_r[2*N-1:N]} + {1'b0, mcand_r};
                end else begin
                    part_s = {1'b0, prod_r[2*N-1:N]};
                end
                prod_nxt_s   = {part_s, prod_r[N-1:1]};
                mplier_nxt_s = {1'b0, mplier_r[N-1:1]};
                cnt_nxt_s    = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Multiply state and datapath registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r  <= IDLE;
            prod_r   <= {(2*N){1'b0}};
            mcand_r  <= {N{1'b0}};
            mplier_r <= {N{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            prod_r   <= prod_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Flag register: loads on fi_ low unless a multiply is running.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cf_r <= 1'b0;
            zf_r <= 1'b0;
            nf_r <= 1'b0;
            vf_r <= 1'b0;
        end else if (!bus_if.fi_ && !busy_s) begin
            cf_r <= cf_nxt_s;
            zf_r <= (res_s == {N{1'b0}});
            nf_r <= res_s[N-1];
            vf_r <= vf_nxt_s;
        end else begin
            cf_r <= cf_r;
            zf_r <= zf_r;
            nf_r <= nf_r;
            vf_r <= vf_r;
        end
    end

    assign bus_if.bus  = bus_if.eo_ ? {N{1'bz}} : res_s;
    assign bus_if.cf   = cf_r;
    assign bus_if.zf   = zf_r;
    assign bus_if.nf   = nf_r;
    assign bus_if.vf   = vf_r;
    assign bus_if.busy = busy_s;

endmodule

// File: tb/tb_alu_flags_mul.sv
// ---------------------------------------------------------------------------
// tb_alu_flags_mul
// Directed scenarios followed by random stimulus, all checked against an
// arithmetic reference model of the ALU, flag register and multiplier.
// ---------------------------------------------------------------------------
module tb_alu_flags_mul;
    localparam int N    = 8;
    localparam int MASK = (1 << N) - 1;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;

    always #5 clk = ~clk;

    alu_flags_mul_if #(.N(N)) ifc ();

    alu_flags_mul #(.N(N)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .bus_if (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_cf, m_zf, m_nf, m_vf;
    int m_cnt;
    int m_prod;
    int m_pend;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
    endfunction

    function automatic void ref_op(input int op, input int a, input int b, input int cfl,
                                   output int res, output int c, output int z,
                                   output int n, output int v);
        int bb, cin, s, ss;
        c = 0;
        v = 0;
        res = 0;
        case (op)
            0, 1, 2, 3: begin
                bb  = (op == 1 || op == 3) ? (~b) & MASK : b;
                cin = (op == 0) ? 0 : (op == 1) ? 1 : cfl;
                s   = a + bb + cin;
                res = s & MASK;
                c   = (s >> N) & 1;
                ss  = sx(a) + sx(bb) + cin;
                v   = (ss > (1 << (N - 1)) - 1 || ss < -(1 << (N - 1))) ? 1 : 0;
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            default: begin
                res = m_prod & MASK;
                c   = ((m_prod >> N) != 0) ? 1 : 0;
                v   = c;
            end
        endcase
        z = (res == 0) ? 1 : 0;
        n = (res >> (N - 1)) & 1;
    endfunction

    task automatic drive(input int a, input int b, input int op, input bit st,
                         input bit eo, input bit fi);
        ifc.a     = a[N-1:0];
        ifc.b     = b[N-1:0];
        ifc.op    = op[2:0];
        ifc.start = st;
        ifc.eo_   = eo;
        ifc.fi_   = fi;
    endtask

    task automatic check_bus(input string tag);
        logic [N-1:0] zz;
        int r, c, z, n, v;
        zz = 'z;
        if (ifc.eo_) begin
            check_val({tag, "_z"}, ifc.bus, zz);
        end else if (!(m_cnt > 0 && ifc.op == 3'd7)) begin
            ref_op(int'(ifc.op), int'(ifc.a), int'(ifc.b), m_cf, r, c, z, n, v);
            check_val(tag, ifc.bus, r[N-1:0]);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_busy"}, ifc.busy, (m_cnt > 0) ? 16'd1 : 16'd0);
        check_val({tag, "_cf"}, ifc.cf, m_cf[0]);
        check_val({tag, "_zf"}, ifc.zf, m_zf[0]);
        check_val({tag, "_nf"}, ifc.nf, m_nf[0]);
        check_val({tag, "_vf"}, ifc.vf, m_vf[0]);
    endtask

    // one clock edge: model update from pre-edge inputs, then check
    task automatic tick(input string tag);
        int r, c, z, n, v;
        bit busy_pre, load, st_ok;
        int pend;
        busy_pre = (m_cnt > 0);
        load     = !ifc.fi_ && !busy_pre;
        ref_op(int'(ifc.op), int'(ifc.a), int'(ifc.b), m_cf, r, c, z, n, v);
        st_ok    = !busy_pre && ifc.start && (ifc.op == 3'd7);
        pend     = int'(ifc.a) * int'(ifc.b);
        @(posedge clk);
        #1;
        if (load) begin
            m_cf = c; m_zf = z; m_nf = n; m_vf = v;
        end
        if (st_ok) begin
            m_cnt  = N;
            m_pend = pend;
        end else if (busy_pre) begin
            m_cnt--;
            if (m_cnt == 0) m_prod = m_pend;
        end
        check_state(tag);
    endtask

    task automatic model_reset();
        m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
        m_cnt = 0; m_prod = 0; m_pend = 0;
    endtask

    // apply inputs, check the combinational bus, then clock once
    task automatic step(input string tag, input int a, input int b, input int op,
                        input bit st, input bit eo, input bit fi);
        drive(a, b, op, st, eo, fi);
        #1;
        check_bus(tag);
        tick(tag);
    endtask

    task automatic count_busy(input string tag, output int cycles);
        cycles = 1;
        while (ifc.busy && cycles < 20) begin
            tick(tag);
            if (ifc.busy) cycles++;
        end
    endtask

    initial begin
        int cyc;
        logic [N-1:0] zz;
        zz = 'z;
        model_reset();
        drive(0, 0, 7, 1'b0, 1'b0, 1'b1);
        #3;
        check_val("rst_bus_mul", ifc.bus, 8'd0);
        check_state("rst");
        ifc.eo_ = 1'b1;
        #1;
        check_val("rst_bus_z", ifc.bus, zz);
        @(negedge clk);
        rst_ = 1'b1;

        // ADD / SUB
        drive(34, 12, 0, 1'b0, 1'b0, 1'b1); #1;
        check_val("add_bus", ifc.bus, 8'd46);
        step("add_fi", 34, 12, 0, 1'b0, 1'b0, 1'b0);
        check_val("add_flags", {ifc.cf, ifc.zf, ifc.nf, ifc.vf}, 4'b0000);
        drive(34, 12, 1, 1'b0, 1'b0, 1'b1); #1;
        check_val("sub_bus", ifc.bus, 8'd22);
        step("sub_fi", 34, 12, 1, 1'b0, 1'b0, 1'b0);
        check_val("sub_cf", ifc.cf, 1'b1);

        // borrow and overflow
        step("sub_borrow", 12, 34, 1, 1'b0, 1'b0, 1'b0);
        drive(12, 34, 1, 1'b0, 1'b0, 1'b1); #1;
        check_val("borrow_bus", ifc.bus, 8'd234);
        check_val("borrow_cn", {ifc.cf, ifc.nf}, 2'b01);
        step("add_ovf", 127, 1, 0, 1'b0, 1'b0, 1'b0);
        check_val("ovf_bus", ifc.bus, 8'd128);
        check_val("ovf_flags", {ifc.cf, ifc.nf, ifc.vf}, 3'b011);

        // wrap and carry chain
        step("add_wrap", 255, 1, 0, 1'b0, 1'b0, 1'b0);
        check_val("wrap_bus", ifc.bus, 8'd0);
        check_val("wrap_cz", {ifc.cf, ifc.zf}, 2'b11);
        step("adc", 0, 0, 2, 1'b0, 1'b0, 1'b1);
        check_val("adc_bus", ifc.bus, 8'd1);
        check_val("adc_hold", {ifc.cf, ifc.zf, ifc.nf, ifc.vf}, 4'b1100);

        // multiply 15*17 with busy-length count
        step("mul_start", 15, 17, 7, 1'b1, 1'b0, 1'b1);
        drive(15, 17, 7, 1'b0, 1'b0, 1'b1);
        count_busy("mul1", cyc);
        check_val("mul1_len", 16'(cyc), 16'd8);
        check_val("mul1_bus", ifc.bus, 8'd255);
        step("mul1_fi", 15, 17, 7, 1'b0, 1'b0, 1'b0);
        check_val("mul1_cn", {ifc.cf, ifc.nf}, 2'b01);

        // 16*16 with hazards: restart, fi_ and operand changes while busy
        step("mul2_start", 16, 16, 7, 1'b1, 1'b0, 1'b1);
        step("mul2_r1", 3, 5, 7, 1'b1, 1'b0, 1'b0);
        step("mul2_r2", 200, 99, 0, 1'b1, 1'b0, 1'b0);
        drive(9, 9, 7, 1'b0, 1'b0, 1'b1);
        count_busy("mul2", cyc);
        check_val("mul2_len", 16'(cyc + 2), 16'd8);
        check_val("mul2_bus", ifc.bus, 8'd0);
        step("mul2_fi", 9, 9, 7, 1'b0, 1'b0, 1'b0);
        check_val("mul2_czv", {ifc.cf, ifc.zf, ifc.vf}, 3'b111);

        // reset during multiply, cycle 4
        step("mul3_start", 200, 200, 7, 1'b1, 1'b0, 1'b1);
        drive(200, 200, 7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("mul3_run");
        rst_ = 1'b0;
        #2;
        model_reset();
        check_state("mid_rst");
        check_val("mid_rst_bus", ifc.bus, 8'd0);
        #2;
        rst_ = 1'b1;

        // randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd", int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
